clint_mtimer_ysyx23060136: RTL and testbench

CLINT_MTIMER_YSYX23060136 -- requirements
Module: clint_mtimer_ysyx23060136

---
 rtl/clint_mtimer_ysyx23060136_pkg.sv | 72 +++++++
 rtl/clint_mtimer_ysyx23060136_prescaler.sv | 30 +++
 rtl/clint_mtimer_ysyx23060136.sv | 167 ++++++++++++++++
 tb/tb_clint_mtimer_ysyx23060136.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clint_mtimer_ysyx23060136_pkg.sv
// CLINT machine-timer shared definitions: register offsets,
// FSM states, address decode and byte-merge helpers.
package clint_mtimer_ysyx23060136_pkg;

    localparam logic [31:0] MSIP_OFFSET     = 32'h0000_0000;
    localparam logic [31:0] MTIMECMP_OFFSET = 32'h0000_4000;
    localparam logic [31:0] MTIME_OFFSET    = 32'h0000_BFF8;

    typedef enum logic {R_IDLE, R_RESP} r_state_t;
    typedef enum logic {W_IDLE, W_RESP} w_state_t;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_MSIP,
        REG_MTIMECMP,
        REG_MTIME
    } reg_kind_t;

    typedef struct packed {
        reg_kind_t  kind;
        logic [1:0] hart;
        logic       hi;
    } reg_sel_t;

    // off is relative to the region base; nh is the hart count.
    function automatic reg_sel_t decode(
        input logic [31:0] off,
        input logic [2:0]  nh
    );
        reg_sel_t s;
        logic     is_msip;
        logic     is_cmp;
        logic     is_time;
        is_msip = (off[31:4] == MSIP_OFFSET[31:4])
               && (off[1:0] == 2'd0)
               && ({1'b0, off[3:2]} < nh);
        is_cmp  = (off[31:5] == MTIMECMP_OFFSET[31:5])
               && (off[2:0] == 3'd0)
               && ({1'b0, off[4:3]} < nh);
        is_time = (off == MTIME_OFFSET);
        s.kind = REG_NONE;
        s.hart = 2'd0;
        s.hi   = off[2];
        unique case (1'b1)
            is_msip: begin
                s.kind = REG_MSIP;
                s.hart = off[3:2];
            end
            is_cmp: begin
                s.kind = REG_MTIMECMP;
                s.hart = off[4:3];
            end
            is_time: s.kind = REG_MTIME;
            default: ;
        endcase
        return s;
    endfunction

    function automatic logic [63:0] merge_bytes(
        input logic [63:0] old,
        input logic [63:0] wd,
        input logic [7:0]  strb
    );
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) begin
            if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/clint_mtimer_ysyx23060136_prescaler.sv
// mtime prescaler: counts 0..TICK_DIV-1, pulses tick on the last count.
// Ports: clk, rst_n (async low), clear (restart at 0), tick (out).
module clint_prescaler_ysyx23060136 #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW =
        (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/clint_mtimer_ysyx23060136.sv
// CLINT timer block: mtime, per-hart mtimecmp/msip, mtip generation.
// Ports: split read (raddr/rdata) and write (waddr/wdata/b) handshakes.
module clint_mtimer_ysyx23060136 #(
    parameter int unsigned NUM_HARTS  = 1,
    parameter int unsigned TICK_DIV   = 1,
    parameter logic [31:0] CLINT_BASE = 32'h0200_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          raddr,
    input  logic                 raddr_valid,
    output logic                 raddr_ready,
    output logic [63:0]          rdata,
    output logic                 rresp_err,
    output logic                 rdata_valid,
    input  logic                 rdata_ready,
    input  logic [31:0]          waddr,
    input  logic [63:0]          wdata,
    input  logic [7:0]           wstrb,
    input  logic                 wvalid,
    output logic                 wready,
    output logic                 bresp_err,
    output logic                 bvalid,
    input  logic                 bready,
    output logic [NUM_HARTS-1:0] mtip,
    output logic [NUM_HARTS-1:0] msip
);

    import clint_mtimer_ysyx23060136_pkg::*;

    localparam logic [2:0] NH = 3'(NUM_HARTS);

    r_state_t              r_state;
    w_state_t              w_state;
    logic [63:0]           mtime_q;
    logic [63:0]           mtimecmp_q [NUM_HARTS];
    logic [NUM_HARTS-1:0]  msip_q;
    logic [63:0]           rd_val;
    reg_sel_t              rsel;
    reg_sel_t              wsel;
    logic                  w_fire;
    logic                  wr_time;
    logic                  tick;
    logic                  msip_bit;
    logic                  msip_en;

    assign rsel    = decode(raddr - CLINT_BASE, NH);
    assign wsel    = decode(waddr - CLINT_BASE, NH);
    assign w_fire  = wvalid && (w_state == W_IDLE);
    assign wr_time = w_fire && (wsel.kind == REG_MTIME);

    assign raddr_ready = (r_state == R_IDLE);
    assign rdata_valid = (r_state == R_RESP);
    assign wready      = (w_state == W_IDLE);
    assign bvalid      = (w_state == W_RESP);
    assign msip        = msip_q;

    // msip sits in the lower or upper word of the 64-bit slot.
    assign msip_bit = wsel.hi ? wdata[32] : wdata[0];
    assign msip_en  = wsel.hi ? wstrb[4] : wstrb[0];

    clint_prescaler_ysyx23060136 #(
        .TICK_DIV (TICK_DIV)
    ) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (wr_time),
        .tick  (tick)
    );

    always_comb begin
        rd_val = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (rsel.hart == 2'(h)) begin
                if (rsel.kind == REG_MSIP) begin
                    rd_val = rsel.hi
                        ? {31'd0, msip_q[h], 32'd0}
                        : {63'd0, msip_q[h]};
                end
                if (rsel.kind == REG_MTIMECMP) begin
                    rd_val = mtimecmp_q[h];
                end
            end
        end
        if (rsel.kind == REG_MTIME) rd_val = mtime_q;
    end

    // A software write to mtime wins over the prescaler tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_q <= '0;
        end else if (wr_time) begin
            mtime_q <= merge_bytes(mtime_q, wdata, wstrb);
        end else if (tick) begin
            mtime_q <= mtime_q + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                mtimecmp_q[h] <= '1;
            end
            msip_q <= '0;
        end else if (w_fire) begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (wsel.hart == 2'(h)) begin
                    if (wsel.kind == REG_MTIMECMP) begin
                        mtimecmp_q[h] <= merge_bytes(
                            mtimecmp_q[h], wdata, wstrb);
                    end
                    if (wsel.kind == REG_MSIP && msip_en) begin
                        msip_q[h] <= msip_bit;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtip <= '0;
        end else begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                mtip[h] <= (mtime_q >= mtimecmp_q[h]);
            end
        end
    end

    // Read data is captured from pre-write register values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= R_IDLE;
            rdata     <= '0;
            rresp_err <= 1'b0;
        end else begin
            unique case (r_state)
                R_IDLE: if (raddr_valid) begin
                    rdata     <= rd_val;
                    rresp_err <= (rsel.kind == REG_NONE);
                    r_state   <= R_RESP;
                end
                R_RESP: if (rdata_ready) begin
                    r_state <= R_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state   <= W_IDLE;
            bresp_err <= 1'b0;
        end else begin
            unique case (w_state)
                W_IDLE: if (wvalid) begin
                    bresp_err <= (wsel.kind == REG_NONE);
                    w_state   <= W_RESP;
                end
                W_RESP: if (bready) begin
                    w_state <= W_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clint_mtimer_ysyx23060136.sv
// Bench for clint_mtimer_ysyx23060136: two instances share stimulus,
// one with TICK_DIV=1/NUM_HARTS=2 and one with TICK_DIV=4/NUM_HARTS=1.
module tb_clint_mtimer_ysyx23060136;

    localparam logic [31:0] B    = 32'h0200_0000;
    localparam logic [31:0] CMP0 = B + 32'h4000;
    localparam logic [31:0] CMP1 = B + 32'h4008;
    localparam logic [31:0] MT   = B + 32'hBFF8;
    localparam logic [63:0] ONES = '1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] raddr = '0;
    logic        raddr_valid = 1'b0;
    logic        rdata_ready = 1'b1;
    logic [31:0] waddr = '0;
    logic [63:0] wdata = '0;
    logic [7:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        bready = 1'b1;

    logic        raddr_ready, rresp_err, rdata_valid;
    logic [63:0] rdata;
    logic        wready, bresp_err, bvalid;
    logic [1:0]  mtip, msip;

    logic        raddr_ready4, rresp_err4, rdata_valid4;
    logic [63:0] rdata4;
    logic        wready4, bresp_err4, bvalid4;
    logic [0:0]  mtip4, msip4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       nm;
        logic [63:0] lo;
        logic [63:0] hi;
        logic        err;
        bit          chk;
    } sb_t;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
        logic [63:0] exp;
        logic        err;
        string       nm;
    } vec_t;

    sb_t  q[$];
    sb_t  q4[$];
    vec_t tbl[19];

    always #5 clk = ~clk;

    clint_mtimer_ysyx23060136 #(
        .NUM_HARTS (2),
        .TICK_DIV  (1)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .raddr (raddr), .raddr_valid (raddr_valid),
        .raddr_ready (raddr_ready), .rdata (rdata),
        .rresp_err (rresp_err), .rdata_valid (rdata_valid),
        .rdata_ready (rdata_ready),
        .waddr (waddr), .wdata (wdata), .wstrb (wstrb),
        .wvalid (wvalid), .wready (wready),
        .bresp_err (bresp_err), .bvalid (bvalid), .bready (bready),
        .mtip (mtip), .msip (msip)
    );

    clint_mtimer_ysyx23060136 #(
        .NUM_HARTS (1),
        .TICK_DIV  (4)
    ) dut4 (
        .clk (clk), .rst_n (rst_n),
        .raddr (raddr), .raddr_valid (raddr_valid),
        .raddr_ready (raddr_ready4), .rdata (rdata4),
        .rresp_err (rresp_err4), .rdata_valid (rdata_valid4),
        .rdata_ready (rdata_ready),
        .waddr (waddr), .wdata (wdata), .wstrb (wstrb),
        .wvalid (wvalid), .wready (wready4),
        .bresp_err (bresp_err4), .bvalid (bvalid4), .bready (bready),
        .mtip (mtip4), .msip (msip4)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic sb_cmp(input sb_t e, input logic [63:0] d,
                          input logic er, input string who);
        checks++;
        if ($isunknown({d, er}) || er !== e.err
            || d < e.lo || d > e.hi) begin
            errors++;
            $display("FAIL %s%s: rdata=%h err=%b expected %h..%h err=%b",
                     e.nm, who, d, er, e.lo, e.hi, e.err);
        end
    endtask

    // Scoreboard: pop one entry per completed read response.
    always @(negedge clk) begin
        sb_t e;
        if (rst_n && rdata_ready && rdata_valid) begin
            if (q.size() == 0) begin
                chk("rd_unexpected", 64'd1, 64'd0);
            end else begin
                e = q.pop_front();
                sb_cmp(e, rdata, rresp_err, "");
            end
        end
        if (rst_n && rdata_ready && rdata_valid4) begin
            if (q4.size() == 0) begin
                chk("rd_unexpected4", 64'd1, 64'd0);
            end else begin
                e = q4.pop_front();
                if (e.chk) sb_cmp(e, rdata4, rresp_err4, "_div4");
            end
        end
    end

    task automatic do_read(input string nm, input logic [31:0] a,
                           input logic [63:0] lo, input logic [63:0] hi,
                           input logic err,
                           input logic [63:0] lo4, input logic [63:0] hi4,
                           input logic err4, input bit c4);
        sb_t e;
        int  n;
        @(negedge clk);
        n = 0;
        while (!raddr_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_rready"}, raddr_ready, 1'b1);
        e.nm = nm; e.lo = lo; e.hi = hi; e.err = err; e.chk = 1'b1;
        q.push_back(e);
        e.lo = lo4; e.hi = hi4; e.err = err4; e.chk = c4;
        q4.push_back(e);
        raddr = a;
        raddr_valid = 1'b1;
        @(posedge clk);
        #1 raddr_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk({nm, "_resp_seen"}, 64'(q.size() + q4.size()), 64'd0);
        q.delete();
        q4.delete();
    endtask

    task automatic do_write(input string nm, input logic [31:0] a,
                            input logic [63:0] d, input logic [7:0] s,
                            input logic err);
        int n;
        @(negedge clk);
        n = 0;
        while (!wready && n < 10) begin
            @(negedge clk);
            n++;
        end
        waddr = a;
        wdata = d;
        wstrb = s;
        wvalid = 1'b1;
        @(posedge clk);
        #1 wvalid = 1'b0;
        @(negedge clk);
        chk({nm, "_bvalid"}, bvalid, 1'b1);
        chk({nm, "_berr"}, bresp_err, err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{0, CMP0, 0, 0, ONES, 0, "cmp0_rst"};
        tbl[1]  = '{0, CMP1, 0, 0, ONES, 0, "cmp1_rst"};
        tbl[2]  = '{0, B, 0, 0, 0, 0, "msip0_rst"};
        tbl[3]  = '{1, B, 64'd1, 8'h01, 0, 0, "msip0_set"};
        tbl[4]  = '{0, B, 0, 0, 64'd1, 0, "msip0_rd1"};
        tbl[5]  = '{1, B, 64'd0, 8'h00, 0, 0, "msip0_nostrb"};
        tbl[6]  = '{0, B, 0, 0, 64'd1, 0, "msip0_rd2"};
        tbl[7]  = '{1, B + 4, 64'h1_0000_0000, 8'h10, 0, 0,
                    "msip1_set"};
        tbl[8]  = '{0, B + 4, 0, 0, 64'h1_0000_0000, 0, "msip1_rd"};
        tbl[9]  = '{1, CMP0, 64'h1122_3344_5566_7788, 8'hFF, 0, 0,
                    "cmp0_wr"};
        tbl[10] = '{1, CMP0, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 0, 0,
                    "cmp0_part"};
        tbl[11] = '{0, CMP0, 0, 0, 64'h1122_3344_AAAA_AAAA, 0,
                    "cmp0_rd"};
        tbl[12] = '{0, B + 32'h8000, 0, 0, 0, 1, "unmap_rd"};
        tbl[13] = '{1, B + 32'h10, ONES, 8'hFF, 0, 1, "unmap_wr"};
        tbl[14] = '{0, B + 32'h4010, 0, 0, 0, 1, "cmp2_unmap"};
        tbl[15] = '{0, B + 32'h4004, 0, 0, 0, 1, "cmp_misalign"};
        tbl[16] = '{0, B + 32'h8, 0, 0, 0, 1, "msip2_unmap"};
        tbl[17] = '{0, B, 0, 0, 64'd1, 0, "msip0_after"};
        tbl[18] = '{0, B + 4, 0, 0, 64'h1_0000_0000, 0,
                    "msip1_after"};

        repeat (3) @(negedge clk);
        chk("rst_rd_side", {rdata_valid, raddr_ready, rresp_err},
            3'b010);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_wr_side", {bvalid, wready, bresp_err}, 3'b010);
        chk("rst_irq", {mtip, msip}, 4'b0000);
        chk("rst_div4", {rdata_valid4, raddr_ready4, bvalid4,
            wready4, bresp_err4, rresp_err4, mtip4, msip4},
            8'b01_01_0000);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        do_read("mtime_10cyc", MT, 64'd10, 64'd12, 1'b0,
                64'd2, 64'd3, 1'b0, 1'b1);
        chk("mtip_idle", {mtip, mtip4}, 3'b000);

        for (int i = 0; i < 19; i++) begin
            if (tbl[i].wr) begin
                do_write(tbl[i].nm, tbl[i].addr, tbl[i].data,
                         tbl[i].strb, tbl[i].err);
            end else begin
                do_read(tbl[i].nm, tbl[i].addr, tbl[i].exp,
                        tbl[i].exp, tbl[i].err, 0, 0, 0, 1'b0);
            end
        end
        chk("msip_out", msip, 2'b11);
        chk("msip_out4", msip4, 1'b1);

        // Same-cycle read and write of one register.
        begin
            sb_t e;
            @(negedge clk);
            e.nm = "rw_same"; e.err = 1'b0; e.chk = 1'b1;
            e.lo = 64'h1122_3344_AAAA_AAAA; e.hi = e.lo;
            q.push_back(e);
            q4.push_back(e);
            raddr = CMP0; raddr_valid = 1'b1;
            waddr = CMP0; wdata = 64'h0123_4567_89AB_CDEF;
            wstrb = 8'hFF; wvalid = 1'b1;
            @(posedge clk);
            #1 raddr_valid = 1'b0;
            wvalid = 1'b0;
            repeat (2) @(negedge clk);
            chk("rw_same_seen", 64'(q.size() + q4.size()), 64'd0);
        end
        do_read("rw_new", CMP0, 64'h0123_4567_89AB_CDEF,
                64'h0123_4567_89AB_CDEF, 1'b0,
                64'h0123_4567_89AB_CDEF,
                64'h0123_4567_89AB_CDEF, 1'b0, 1'b1);

        // mtip timing around mtime crossing mtimecmp[1].
        do_write("cmp1_20", CMP1, 64'h20, 8'hFF, 1'b0);
        do_write("mtime_1e", MT, 64'h1E, 8'hFF, 1'b0);
        @(negedge clk);
        chk("mtip_1e", mtip, 2'b00);
        @(negedge clk);
        chk("mtip_1f", mtip, 2'b00);
        @(negedge clk);
        chk("mtip_20", mtip, 2'b10);
        do_write("cmp1_ones", CMP1, ONES, 8'hFF, 1'b0);
        chk("mtip1_lag", mtip[1], 1'b1);
        @(negedge clk);
        chk("mtip1_clr", mtip[1], 1'b0);

        // Prescaler restart on mtime write.
        do_write("mtime_zero", MT, 64'd0, 8'hFF, 1'b0);
        repeat (15) @(negedge clk);
        do_read("mtime_16cyc", MT, 64'd16, 64'd16, 1'b0,
                64'd3, 64'd5, 1'b0, 1'b1);

        // Back-pressure hold, then reset mid-response.
        @(negedge clk);
        rdata_ready = 1'b0;
        raddr = CMP0;
        raddr_valid = 1'b1;
        @(posedge clk);
        #1 raddr_valid = 1'b0;
        @(negedge clk);
        waddr = CMP0; wdata = 64'd0; wstrb = 8'hFF; wvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) wvalid = 1'b0;
            chk("hold_valid", {rdata_valid, rdata_valid4}, 2'b11);
            chk("hold_ready", {raddr_ready, raddr_ready4}, 2'b00);
            chk("hold_data", rdata, 64'h0123_4567_89AB_CDEF);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("abort_valid", {rdata_valid, rdata_valid4}, 2'b00);
        chk("abort_ready", {raddr_ready, raddr_ready4}, 2'b11);
        chk("abort_rdata", rdata, 64'd0);
        rdata_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_valid", {rdata_valid, bvalid}, 2'b00);
        do_read("cmp0_post_rst", CMP0, ONES, ONES, 1'b0,
                ONES, ONES, 1'b0, 1'b1);
        do_read("msip0_post_rst", B, 64'd0, 64'd0, 1'b0,
                64'd0, 64'd0, 1'b0, 1'b1);

        chk("sb_empty", 64'(q.size() + q4.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
